// File: rtl/bola_pkg.sv
// Shared screen geometry and ball state encoding for the ball block.
package bola_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        PRESA   = 2'd0,
        VOANDO  = 2'd1,
        PERDIDA = 2'd2
    } estado_t;
endpackage

// File: rtl/divisor_tick.sv
// Clock divider producing a one-clock tick every MOVE_DIV enabled clocks.
module divisor_tick #(
    parameter int MOVE_DIV = 250000
) (
    input  logic CLOCK_50,
    input  logic resetQNave,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);
    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == CW'(MOVE_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge resetQNave) begin
        if (resetQNave) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bola.sv
// Ball controller: rides on the ship, flies with wall/ship reflections, and
// sits out a penalty period after leaving through the bottom edge.
module bola
    import bola_pkg::*;
#(
    parameter int BALL_SIZE  = 8,
    parameter int STEP       = 2,
    parameter int MOVE_DIV   = 250000,
    parameter int LOST_DELAY = 100
) (
    input  logic       CLOCK_50,
    input  logic       resetQNave,
    input  logic       reiniciarJogo,
    input  logic       pausa,
    input  logic       lancar,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] largura_nave,
    input  logic [9:0] altura_nave,
    output logic [9:0] x_bola,
    output logic [9:0] y_bola,
    output logic       bateu,
    output logic       perdeu,
    output logic [1:0] estado
);
    localparam int LW = $clog2(LOST_DELAY + 1);
    localparam logic signed [10:0] STEP_P = 11'(STEP);
    localparam logic signed [10:0] STEP_N = -11'(STEP);
    localparam logic signed [11:0] BS_W   = 12'(BALL_SIZE);
    localparam logic signed [11:0] SW_W   = 12'(SCREEN_W);
    localparam logic signed [11:0] SH_W   = 12'(SCREEN_H);
    localparam logic [9:0] BS10   = 10'(BALL_SIZE);
    localparam logic [9:0] HALF10 = 10'(BALL_SIZE / 2);
    localparam logic [9:0] XMAX   = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0] YMAX   = 10'(SCREEN_H - BALL_SIZE);

    estado_t estado_q, estado_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
    logic [LW-1:0] lost_q, lost_d;
    logic lancar_q, lancar_d, bateu_q, bateu_d, perdeu_q, perdeu_d;
    logic launch, tick, ship_hit;
    logic signed [10:0] xn, yn;
    logic signed [11:0] xn_w, yn_w, y_w, ys_w, xs_w, xs_r_w;

    // Ship height plays no part in the collision rule.
    logic unused_altura;
    assign unused_altura = ^altura_nave;

    divisor_tick #(.MOVE_DIV(MOVE_DIV)) u_tick (
        .CLOCK_50  (CLOCK_50),
        .resetQNave(resetQNave),
        .enable_i  (!pausa && !reiniciarJogo && (estado_q != PRESA)),
        .clear_i   (reiniciarJogo || launch),
        .tick_o    (tick)
    );

    always_comb begin
        xn     = $signed({1'b0, x_q}) + dx_q;
        yn     = $signed({1'b0, y_q}) + dy_q;
        xn_w   = {xn[10], xn};
        yn_w   = {yn[10], yn};
        y_w    = {2'b00, y_q};
        ys_w   = {2'b00, y_nave};
        xs_w   = {2'b00, x_nave};
        xs_r_w = xs_w + $signed({2'b00, largura_nave});
        ship_hit = (dy_q > 0) && (y_w + BS_W <= ys_w) && (yn_w + BS_W >= ys_w)
                   && (xn_w + BS_W > xs_w) && (xn_w < xs_r_w);
    end

    always_comb begin
        estado_d = estado_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        lost_d   = lost_q;
        lancar_d = lancar;
        bateu_d  = 1'b0;
        perdeu_d = 1'b0;
        launch   = 1'b0;
        if (reiniciarJogo) begin
            estado_d = PRESA;
            x_d      = '0;
            y_d      = '0;
            dx_d     = STEP_P;
            dy_d     = STEP_N;
            lost_d   = '0;
            lancar_d = 1'b0;
        end else if (!pausa) begin
            case (estado_q)
                PRESA: begin
                    x_d = x_nave + {1'b0, largura_nave[9:1]} - HALF10;
                    y_d = y_nave - BS10;
                    if (lancar && !lancar_q) begin
                        launch   = 1'b1;
                        estado_d = VOANDO;
                        dx_d     = STEP_P;
                        dy_d     = STEP_N;
                    end
                end
                VOANDO: if (tick) begin
                    if (xn <= 0) begin
                        x_d  = '0;
                        dx_d = STEP_P;
                    end else if (xn_w + BS_W >= SW_W) begin
                        x_d  = XMAX;
                        dx_d = STEP_N;
                    end else begin
                        x_d = xn[9:0];
                    end
                    // Ship contact outranks the bottom edge on the same tick.
                    if (yn <= 0) begin
                        y_d  = '0;
                        dy_d = STEP_P;
                    end else if (ship_hit) begin
                        y_d     = y_nave - BS10;
                        dy_d    = STEP_N;
                        bateu_d = 1'b1;
                    end else if (yn_w + BS_W >= SH_W) begin
                        y_d      = YMAX;
                        perdeu_d = 1'b1;
                        estado_d = PERDIDA;
                        lost_d   = '0;
                    end else begin
                        y_d = yn[9:0];
                    end
                end
                PERDIDA: if (tick) begin
                    if (lost_q == LW'(LOST_DELAY - 1)) begin
                        estado_d = PRESA;
                        lost_d   = '0;
                    end else begin
                        lost_d = lost_q + LW'(1);
                    end
                end
                default: estado_d = PRESA;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge resetQNave) begin
        if (resetQNave) begin
            estado_q <= PRESA;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= STEP_P;
            dy_q     <= STEP_N;
            lost_q   <= '0;
            lancar_q <= 1'b0;
            bateu_q  <= 1'b0;
            perdeu_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            lost_q   <= lost_d;
            lancar_q <= lancar_d;
            bateu_q  <= bateu_d;
            perdeu_q <= perdeu_d;
        end
    end

    assign x_bola = x_q;
    assign y_bola = y_q;
    assign bateu  = bateu_q;
    assign perdeu = perdeu_q;
    assign estado = estado_q;
endmodule

// File: tb/tb_bola.sv
// Randomized and directed bench for the ball controller against an integer model.
module tb_bola;
    localparam int MOVE_DIV = 2, STEP = 2, BS = 8, LOST_DELAY = 4;

    logic CLOCK_50 = 1'b0;
    logic resetQNave, reiniciarJogo, pausa, lancar;
    logic [9:0] x_nave, y_nave, largura_nave, altura_nave;
    logic [9:0] x_bola, y_bola;
    logic bateu, perdeu;
    logic [1:0] estado;

    int total = 0;
    int bad = 0;
    int ms, mx, my, mdx, mdy, mcnt, mlost, mlp, mb, mp;

    bola #(.BALL_SIZE(BS), .STEP(STEP), .MOVE_DIV(MOVE_DIV), .LOST_DELAY(LOST_DELAY)) dut (
        .CLOCK_50(CLOCK_50), .resetQNave(resetQNave), .reiniciarJogo(reiniciarJogo),
        .pausa(pausa), .lancar(lancar), .x_nave(x_nave), .y_nave(y_nave),
        .largura_nave(largura_nave), .altura_nave(altura_nave), .x_bola(x_bola),
        .y_bola(y_bola), .bateu(bateu), .perdeu(perdeu), .estado(estado)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic void model_reset();
        ms = 0; mx = 0; my = 0; mdx = STEP; mdy = -STEP;
        mcnt = 0; mlost = 0; mlp = 0; mb = 0; mp = 0;
    endfunction

    // Reference: game rules applied with plain integers once per clock edge.
    function automatic void model_step();
        int xs, ys, ws, nx, ny;
        bit tk;
        xs = x_nave; ys = y_nave; ws = largura_nave;
        if (resetQNave || reiniciarJogo) begin
            model_reset();
            return;
        end
        if (pausa) begin
            mlp = lancar; mb = 0; mp = 0;
            return;
        end
        mb = 0; mp = 0;
        tk = (ms != 0) && (mcnt == MOVE_DIV - 1);
        if (ms != 0) mcnt = tk ? 0 : mcnt + 1;
        if (ms == 0) begin
            mx = (xs + ws / 2 - BS / 2) & 1023;
            my = (ys - BS) & 1023;
            if (lancar && !mlp) begin
                ms = 1; mdx = STEP; mdy = -STEP; mcnt = 0;
            end
        end else if (ms == 1 && tk) begin
            nx = mx + mdx; ny = my + mdy;
            if (nx <= 0) begin mx = 0; mdx = STEP; end
            else if (nx + BS >= 640) begin mx = 640 - BS; mdx = -STEP; end
            else mx = nx;
            if (ny <= 0) begin my = 0; mdy = STEP; end
            else if (mdy > 0 && my + BS <= ys && ny + BS >= ys && nx + BS > xs && nx < xs + ws) begin
                my = ys - BS; mdy = -STEP; mb = 1;
            end else if (ny + BS >= 480) begin
                my = 480 - BS; mp = 1; ms = 2; mlost = 0;
            end else my = ny;
        end else if (ms == 2 && tk) begin
            mlost++;
            if (mlost == LOST_DELAY) begin ms = 0; mlost = 0; end
        end
        mlp = lancar;
    endfunction

    task automatic clk1();
        @(posedge CLOCK_50);
        model_step();
        #1;
    endtask

    function automatic bit drifted();
        return (x_bola !== 10'(mx)) || (y_bola !== 10'(my)) || (estado !== 2'(ms))
            || (bateu !== 1'(mb)) || (perdeu !== 1'(mp));
    endfunction

    task automatic test_reset();
        resetQNave = 1'b1; reiniciarJogo = 1'b0; pausa = 1'b0; lancar = 1'b0;
        x_nave = 10'd350; y_nave = 10'd240; largura_nave = 10'd64; altura_nave = 10'd16;
        model_reset();
        clk1(); clk1();
        total++;
        if (estado !== 2'd0 || x_bola !== 10'd0 || y_bola !== 10'd0 || bateu !== 1'b0 || perdeu !== 1'b0) begin
            bad++; $display("FAIL reset_state: estado=%0d x=%0d y=%0d b=%b p=%b want 0 0 0 0 0", estado, x_bola, y_bola, bateu, perdeu);
        end
        resetQNave = 1'b0;
        clk1();
        total++;
        if (x_bola !== 10'd378 || y_bola !== 10'd232 || estado !== 2'd0) begin
            bad++; $display("FAIL presa_track: x=%0d y=%0d estado=%0d want 378 232 0", x_bola, y_bola, estado);
        end
    endtask

    task automatic test_launch();
        lancar = 1'b1;
        clk1();
        total++;
        if (estado !== 2'd1) begin bad++; $display("FAIL launch_state: estado=%0d want 1", estado); end
        clk1();
        total++;
        if (x_bola !== 10'd378 || y_bola !== 10'd232) begin
            bad++; $display("FAIL launch_wait: x=%0d y=%0d want 378 232", x_bola, y_bola);
        end
        clk1();
        total++;
        if (x_bola !== 10'd380 || y_bola !== 10'd230) begin
            bad++; $display("FAIL first_tick: x=%0d y=%0d want 380 230", x_bola, y_bola);
        end
    endtask

    task automatic test_walls();
        int n = 0, drift = 0;
        while (!(ms == 1 && mx == 630 && mdx > 0) && n < 3000) begin
            clk1(); n++;
            if (drifted()) drift++;
        end
        total++;
        if (n >= 3000 || drift != 0) begin
            bad++; $display("FAIL walls_track: clocks=%0d drift=%0d x=%0d want model %0d", n, drift, x_bola, mx);
        end
        n = 0;
        while (mx == 630 && n < 10) begin clk1(); n++; end
        total++;
        if (x_bola !== 10'd632) begin bad++; $display("FAIL right_wall_clamp: x=%0d want 632", x_bola); end
        n = 0;
        while (mx == 632 && n < 10) begin clk1(); n++; end
        total++;
        if (x_bola !== 10'd630) begin bad++; $display("FAIL right_wall_reflect: x=%0d want 630", x_bola); end
    endtask

    task automatic test_ship_hit();
        int n = 0, drift = 0;
        while (!(ms == 1 && my == 230 && mdy > 0) && n < 3000) begin
            clk1(); n++;
            if (drifted()) drift++;
        end
        total++;
        if (n >= 3000 || drift != 0) begin
            bad++; $display("FAIL ship_approach: clocks=%0d drift=%0d y=%0d want model %0d", n, drift, y_bola, my);
        end
        x_nave = 10'(mx - 10);
        total++;
        if (bateu !== 1'b0) begin bad++; $display("FAIL bateu_before: bateu=%b want 0", bateu); end
        n = 0;
        while (my == 230 && n < 10) begin clk1(); n++; end
        total++;
        if (y_bola !== 10'd232 || bateu !== 1'b1) begin
            bad++; $display("FAIL ship_hit: y=%0d bateu=%b want 232 1", y_bola, bateu);
        end
        clk1();
        total++;
        if (bateu !== 1'b0) begin bad++; $display("FAIL bateu_width: bateu=%b want 0", bateu); end
        n = 0;
        while (my == 232 && n < 10) begin clk1(); n++; end
        total++;
        if (y_bola !== 10'd230) begin bad++; $display("FAIL ship_reflect: y=%0d want 230", y_bola); end
    endtask

    task automatic test_loss();
        int n = 0, drift = 0;
        x_nave = 10'd1000; largura_nave = 10'd10;
        while (!(ms == 1 && my == 470 && mdy > 0) && n < 4000) begin
            clk1(); n++;
            if (drifted()) drift++;
        end
        total++;
        if (n >= 4000 || drift != 0) begin
            bad++; $display("FAIL loss_approach: clocks=%0d drift=%0d y=%0d want model %0d", n, drift, y_bola, my);
        end
        n = 0;
        while (mp == 0 && n < 10) begin clk1(); n++; end
        total++;
        if (perdeu !== 1'b1 || y_bola !== 10'd472 || estado !== 2'd2) begin
            bad++; $display("FAIL loss_event: perdeu=%b y=%0d estado=%0d want 1 472 2", perdeu, y_bola, estado);
        end
        clk1();
        total++;
        if (perdeu !== 1'b0) begin bad++; $display("FAIL perdeu_width: perdeu=%b want 0", perdeu); end
        repeat (6) clk1();
        total++;
        if (estado !== 2'd2 || y_bola !== 10'd472) begin
            bad++; $display("FAIL lost_hold: estado=%0d y=%0d want 2 472", estado, y_bola);
        end
        clk1();
        total++;
        if (estado !== 2'd0) begin bad++; $display("FAIL lost_exit: estado=%0d want 0", estado); end
        clk1();
        total++;
        if (x_bola !== 10'd1001 || y_bola !== 10'd232) begin
            bad++; $display("FAIL presa_return: x=%0d y=%0d want 1001 232", x_bola, y_bola);
        end
    endtask

    task automatic test_pause();
        int sx, sy, err = 0;
        x_nave = 10'd350; largura_nave = 10'd64;
        lancar = 1'b0; clk1();
        lancar = 1'b1; clk1();
        repeat (5) clk1();
        sx = mx; sy = my;
        pausa = 1'b1;
        for (int i = 0; i < 100; i++) begin
            lancar = 1'($urandom_range(0, 1));
            clk1();
            if (x_bola !== 10'(sx) || y_bola !== 10'(sy) || estado !== 2'd1 || bateu !== 1'b0 || perdeu !== 1'b0) err++;
        end
        total++;
        if (err != 0) begin bad++; $display("FAIL pause_hold: changed_clocks=%0d want 0 (x=%0d want %0d)", err, x_bola, sx); end
        // Restart wins over pause; a launch edge while paused is dropped.
        reiniciarJogo = 1'b1; clk1(); reiniciarJogo = 1'b0;
        total++;
        if (estado !== 2'd0 || x_bola !== 10'd0 || y_bola !== 10'd0) begin
            bad++; $display("FAIL restart_in_pause: estado=%0d x=%0d y=%0d want 0 0 0", estado, x_bola, y_bola);
        end
        lancar = 1'b0; clk1();
        lancar = 1'b1; clk1();
        pausa = 1'b0; clk1();
        total++;
        if (estado !== 2'd0 || x_bola !== 10'd378 || y_bola !== 10'd232) begin
            bad++; $display("FAIL paused_edge_ignored: estado=%0d x=%0d y=%0d want 0 378 232", estado, x_bola, y_bola);
        end
    endtask

    task automatic test_async_reset();
        int err = 0;
        lancar = 1'b0; clk1();
        lancar = 1'b1; clk1();
        repeat (7) clk1();
        #3 resetQNave = 1'b1;
        model_reset();
        #1;
        total++;
        if (estado !== 2'd0 || x_bola !== 10'd0 || y_bola !== 10'd0) begin
            bad++; $display("FAIL async_reset: estado=%0d x=%0d y=%0d want 0 0 0", estado, x_bola, y_bola);
        end
        repeat (3) begin
            clk1();
            if (bateu !== 1'b0 || perdeu !== 1'b0 || estado !== 2'd0) err++;
        end
        total++;
        if (err != 0) begin bad++; $display("FAIL reset_no_pulse: bad_clocks=%0d want 0", err); end
        resetQNave = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pausa = ($urandom_range(0, 9) == 0);
            reiniciarJogo = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) lancar = ~lancar;
            if (i % 50 == 0) begin
                x_nave = 10'($urandom_range(0, 560));
                largura_nave = 10'($urandom_range(16, 96));
                y_nave = 10'($urandom_range(200, 460));
            end
            clk1();
            total++;
            if (drifted()) begin
                bad++;
                if (bad < 20)
                    $display("FAIL random_%0d: x=%0d y=%0d st=%0d b=%b p=%b want %0d %0d %0d %0d %0d",
                             i, x_bola, y_bola, estado, bateu, perdeu, mx, my, ms, mb, mp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_walls();
        test_ship_hit();
        test_loss();
        test_pause();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
